// File: rtl/tran_frame_ctrl.sv
// Transmit framer: pops payload bytes from the TX byte FIFO and wraps them
// as preamble / SFD / payload / CRC-8 for the serializer, then enforces an
// inter-frame gap before the next frame may start.
module tran_frame_ctrl #(
   parameter int unsigned PREAMBLE_LEN = 2,
   parameter logic [7:0]  SFD_BYTE     = 8'hD0,
   parameter int unsigned MAX_PAYLOAD  = 255,
   parameter int unsigned IFG_CYCLES   = 16
) (
   input  logic       clk_system,
   input  logic       rst,
   input  logic       xsnd,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       tx_last,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] payload_len
);

   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
   localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);
   localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_SFD   = 3'd2,
      S_FETCH = 3'd3,
      S_WAIT  = 3'd4,
      S_DATA  = 3'd5,
      S_CRC   = 3'd6,
      S_GAP   = 3'd7
   } state_t;

   // CRC-8, polynomial 0x07, MSB first, one full byte per call.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ 8'h07;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   state_t     state_r;
   state_t     state_s;
   logic [3:0] pre_cnt_r;
   logic [3:0] pre_cnt_s;
   logic [7:0] byte_cnt_r;
   logic [7:0] byte_cnt_s;
   logic [7:0] gap_cnt_r;
   logic [7:0] gap_cnt_s;
   logic [7:0] crc_r;
   logic [7:0] crc_s;
   logic [7:0] tx_data_s;
   logic       tx_valid_s;
   logic       tx_last_s;
   logic       fifo_rd_s;
   logic       frame_done_s;
   logic [7:0] payload_len_s;
   logic       busy_s;
   logic       xfer_s;

   assign xfer_s = tx_valid && tx_ready;

   // Next-state and next-output decode; every register holds unless its state acts.
   always_comb begin
      state_s       = state_r;
      pre_cnt_s     = pre_cnt_r;
      byte_cnt_s    = byte_cnt_r;
      gap_cnt_s     = gap_cnt_r;
      crc_s         = crc_r;
      tx_data_s     = tx_data;
      tx_valid_s    = tx_valid;
      tx_last_s     = tx_last;
      fifo_rd_s     = 1'b0;
      frame_done_s  = 1'b0;
      payload_len_s = payload_len;
      case (state_r)
         S_IDLE: begin
            // Empty frames are never started: wait for data as well as a request.
            if (xsnd && !fifo_empty) begin
               state_s    = S_PRE;
               pre_cnt_s  = 4'd0;
               byte_cnt_s = 8'd0;
               crc_s      = 8'h00;
               tx_data_s  = PRE_BYTE;
               tx_valid_s = 1'b1;
               tx_last_s  = 1'b0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PRE: begin
            if (xfer_s) begin
               if (pre_cnt_r == PRE_LAST) begin
                  state_s   = S_SFD;
                  tx_data_s = SFD_BYTE;
               end else begin
                  pre_cnt_s = pre_cnt_r + 4'd1;
               end
            end else begin
               state_s = S_PRE;
            end
         end
         S_SFD: begin
            // FIFO was non-empty when the frame started and nothing has popped since.
            if (xfer_s) begin
               state_s    = S_FETCH;
               tx_valid_s = 1'b0;
               fifo_rd_s  = 1'b1;
            end else begin
               state_s = S_SFD;
            end
         end
         S_FETCH: begin
            state_s = S_WAIT;
         end
         S_WAIT: begin
            state_s    = S_DATA;
            tx_data_s  = fifo_data;
            tx_valid_s = 1'b1;
            crc_s      = crc8_update(crc_r, fifo_data);
            byte_cnt_s = byte_cnt_r + 8'd1;
         end
         S_DATA: begin
            if (xfer_s) begin
               if ((byte_cnt_r < MAX_LEN) && !fifo_empty) begin
                  state_s    = S_FETCH;
                  tx_valid_s = 1'b0;
                  fifo_rd_s  = 1'b1;
               end else begin
                  state_s   = S_CRC;
                  tx_data_s = crc_r;
                  tx_last_s = 1'b1;
               end
            end else begin
               state_s = S_DATA;
            end
         end
         S_CRC: begin
            if (xfer_s) begin
               state_s       = S_GAP;
               tx_valid_s    = 1'b0;
               tx_last_s     = 1'b0;
               frame_done_s  = 1'b1;
               payload_len_s = byte_cnt_r;
               gap_cnt_s     = 8'd0;
            end else begin
               state_s = S_CRC;
            end
         end
         S_GAP: begin
            // Requests are deliberately not looked at here; only IDLE samples xsnd.
            if (gap_cnt_r == GAP_LAST) begin
               state_s = S_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s    = S_IDLE;
            tx_valid_s = 1'b0;
            tx_last_s  = 1'b0;
         end
      endcase
      busy_s = (state_s != S_IDLE);
   end

   // State, counters, CRC and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge clk_system or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         pre_cnt_r   <= 4'd0;
         byte_cnt_r  <= 8'd0;
         gap_cnt_r   <= 8'd0;
         crc_r       <= 8'h00;
         tx_data     <= 8'h00;
         tx_valid    <= 1'b0;
         tx_last     <= 1'b0;
         fifo_rd     <= 1'b0;
         frame_done  <= 1'b0;
         payload_len <= 8'h00;
         busy        <= 1'b0;
      end else begin
         state_r     <= state_s;
         pre_cnt_r   <= pre_cnt_s;
         byte_cnt_r  <= byte_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
         crc_r       <= crc_s;
         tx_data     <= tx_data_s;
         tx_valid    <= tx_valid_s;
         tx_last     <= tx_last_s;
         fifo_rd     <= fifo_rd_s;
         frame_done  <= frame_done_s;
         payload_len <= payload_len_s;
         busy        <= busy_s;
      end
   end

endmodule

// File: tb/tb_tran_frame_ctrl.sv
// Self-checking bench for tran_frame_ctrl: FIFO model, transfer monitor and a
// frame-level reference (chunking plus CRC by polynomial long division).
module tb_tran_frame_ctrl;

   localparam int         PRE_N = 2;
   localparam int         MAXP  = 4;
   localparam int         IFG   = 16;
   localparam logic [7:0] SFD   = 8'hD0;

   logic       clk_system;
   logic       rst;
   logic       xsnd;
   logic       fifo_empty;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_rd;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_last;
   logic       busy;
   logic       frame_done;
   logic [7:0] payload_len;

   int n_pass  = 0;
   int n_total = 0;

   tran_frame_ctrl #(
      .PREAMBLE_LEN(PRE_N),
      .SFD_BYTE    (SFD),
      .MAX_PAYLOAD (MAXP),
      .IFG_CYCLES  (IFG)
   ) dut (
      .clk_system (clk_system),
      .rst        (rst),
      .xsnd       (xsnd),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_last    (tx_last),
      .busy       (busy),
      .frame_done (frame_done),
      .payload_len(payload_len)
   );

   initial clk_system = 1'b0;
   always #5 clk_system = ~clk_system;

   // FIFO model: data appears the cycle after a pop strobe.
   logic [7:0] mem [0:255];
   int wp      = 0;
   int rp      = 0;
   int bad_pop = 0;
   assign fifo_empty = (wp == rp);

   // Pop on the strobe edge; count any pop attempted while empty.
   always @(posedge clk_system) begin
      if (fifo_rd) begin
         if (wp == rp) bad_pop <= bad_pop + 1;
         else begin
            fifo_data <= mem[rp & 255];
            rp        <= rp + 1;
         end
      end
   end

   // Transfer monitor, sampled mid-cycle (inputs change just after posedge).
   logic [7:0] rec_data [0:4095];
   logic       rec_last [0:4095];
   logic [7:0] len_log  [0:255];
   int   nrec     = 0;
   int   n_rd     = 0;
   int   n_done   = 0;
   int   stab_err = 0;
   logic hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;
   logic hold_last = 1'b0;

   // Record transfers, pops, frame completions and hold-stability violations.
   always @(negedge clk_system) begin
      if (rst) begin
         hold_pend <= 1'b0;
      end else begin
         if (hold_pend && (tx_valid !== 1'b1 || tx_data !== hold_data || tx_last !== hold_last))
            stab_err <= stab_err + 1;
         if (tx_valid && tx_ready) begin
            rec_data[nrec & 4095] <= tx_data;
            rec_last[nrec & 4095] <= tx_last;
            nrec <= nrec + 1;
         end
         hold_pend <= tx_valid && !tx_ready;
         hold_data <= tx_data;
         hold_last <= tx_last;
         if (fifo_rd) n_rd <= n_rd + 1;
         if (frame_done) begin
            len_log[n_done & 255] <= payload_len;
            n_done <= n_done + 1;
         end
      end
   end

   // Reference model state.
   logic [7:0] pay_q [$];
   logic [7:0] exp_d [$];
   logic       exp_l [$];

   // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] ref_crc(input int first, input int n);
      logic [8:0] r;
      logic [7:0] b;
      r = 9'd0;
      for (int k = 0; k < n + 1; k++) begin
         b = (k < n) ? pay_q[first + k] : 8'h00;
         for (int j = 7; j >= 0; j--) begin
            r = {r[7:0], b[j]};
            if (r[8]) r = r ^ 9'h107;
         end
      end
      return r[7:0];
   endfunction

   task automatic build_expected();
      int i;
      int n;
      exp_d.delete();
      exp_l.delete();
      i = 0;
      while (i < pay_q.size()) begin
         n = pay_q.size() - i;
         if (n > MAXP) n = MAXP;
         for (int k = 0; k < PRE_N; k++) begin
            exp_d.push_back(8'h55); exp_l.push_back(1'b0);
         end
         exp_d.push_back(SFD); exp_l.push_back(1'b0);
         for (int k = 0; k < n; k++) begin
            exp_d.push_back(pay_q[i + k]); exp_l.push_back(1'b0);
         end
         exp_d.push_back(ref_crc(i, n)); exp_l.push_back(1'b1);
         i = i + n;
      end
   endtask

   function automatic int stream_errs(input int start);
      int e;
      int n;
      e = 0;
      n = nrec - start;
      if (n != exp_d.size()) e = e + 1;
      for (int i = 0; i < exp_d.size() && i < n; i++)
         if (rec_data[(start + i) & 4095] !== exp_d[i] || rec_last[(start + i) & 4095] !== exp_l[i])
            e = e + 1;
      return e;
   endfunction

   task automatic load(input logic [7:0] b);
      mem[wp & 255] = b;
      wp = wp + 1;
      pay_q.push_back(b);
   endtask

   task automatic step();
      @(posedge clk_system);
      #2;
   endtask

   task automatic wait_frames(input int target, input int mode, output bit ok);
      int guard;
      guard = 0;
      ok = 1'b0;
      while (guard < 3000) begin
         if (n_done >= target) begin
            ok = 1'b1;
            break;
         end
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = !tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         step();
         guard++;
      end
   endtask

   task automatic wait_idle(output bit ok);
      int guard;
      guard = 0;
      tx_ready = 1'b1;
      while (busy !== 1'b0 && guard < 300) begin
         step();
         guard++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_total++;
      if ({tx_valid, tx_last, busy, fifo_rd, frame_done} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {tx_valid, tx_last, busy, fifo_rd, frame_done});
      else n_pass++;
      n_total++;
      if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data);
      else n_pass++;
      n_total++;
      if (payload_len !== 8'h00) $display("FAIL reset_payload_len: got %h want 00", payload_len);
      else n_pass++;
      rst = 1'b0;
      step();
      step();
      n_total++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL reset_idle: busy %b valid %b want 0 0", busy, tx_valid);
      else n_pass++;
   endtask

   task automatic test_single_byte();
      int s, d0, r0;
      bit ok, ok2;
      pay_q.delete();
      load(8'h01);
      build_expected();
      s = nrec; d0 = n_done; r0 = n_rd;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 0, ok);
      xsnd = 1'b0;
      wait_idle(ok2);
      n_total++;
      if (!(ok && ok2)) $display("FAIL single_timeout: got %b%b want 11", ok, ok2);
      else n_pass++;
      n_total++;
      if (stream_errs(s) != 0) $display("FAIL single_stream: got %0d bytes/%0d errs want %0d bytes/0 errs", nrec - s, stream_errs(s), exp_d.size());
      else n_pass++;
      n_total++;
      if (n_done - d0 != 1) $display("FAIL single_frame_done: got %0d want 1", n_done - d0);
      else n_pass++;
      n_total++;
      if (len_log[d0 & 255] !== 8'd1) $display("FAIL single_payload_len: got %0d want 1", len_log[d0 & 255]);
      else n_pass++;
      n_total++;
      if (n_rd - r0 != 1) $display("FAIL single_fifo_rd: got %0d want 1", n_rd - r0);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int s, d0, e0;
      bit ok, ok2;
      pay_q.delete();
      load(8'h01);
      load(8'h02);
      build_expected();
      s = nrec; d0 = n_done; e0 = stab_err;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 1, ok);
      xsnd = 1'b0;
      wait_idle(ok2);
      n_total++;
      if (!(ok && ok2)) $display("FAIL bp_timeout: got %b%b want 11", ok, ok2);
      else n_pass++;
      n_total++;
      if (stream_errs(s) != 0) $display("FAIL bp_stream: got %0d bytes/%0d errs want %0d bytes/0 errs", nrec - s, stream_errs(s), exp_d.size());
      else n_pass++;
      n_total++;
      if (stab_err != e0) $display("FAIL bp_hold_stable: got %0d violations want 0", stab_err - e0);
      else n_pass++;
      n_total++;
      if (len_log[d0 & 255] !== 8'd2) $display("FAIL bp_payload_len: got %0d want 2", len_log[d0 & 255]);
      else n_pass++;
   endtask

   task automatic test_empty_request();
      int viol, s;
      viol = 0;
      s = nrec;
      tx_ready = 1'b1;
      xsnd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy !== 1'b0 || fifo_rd !== 1'b0 || tx_valid !== 1'b0) viol++;
      end
      xsnd = 1'b0;
      n_total++;
      if (viol != 0 || nrec != s) $display("FAIL empty_request: got %0d active cycles/%0d bytes want 0/0", viol, nrec - s);
      else n_pass++;
   endtask

   task automatic test_max_split();
      int s, d0, r0, g;
      bit ok, ok2, ok3;
      pay_q.delete();
      load(8'h11); load(8'h22); load(8'h33);
      load(8'h44); load(8'h55); load(8'h66);
      build_expected();
      s = nrec; d0 = n_done; r0 = n_rd;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 0, ok);
      n_total++;
      if (len_log[d0 & 255] !== 8'd4) $display("FAIL split_len_first: got %0d want 4", len_log[d0 & 255]);
      else n_pass++;
      // The cycle carrying frame_done has already elapsed when this loop starts.
      g = 1;
      while (busy === 1'b1 && g < 400) begin
         g++;
         step();
      end
      n_total++;
      if (g != IFG) $display("FAIL split_gap_len: got %0d want %0d", g, IFG);
      else n_pass++;
      wait_frames(d0 + 2, 0, ok2);
      xsnd = 1'b0;
      wait_idle(ok3);
      n_total++;
      if (!(ok && ok2 && ok3)) $display("FAIL split_timeout: got %b%b%b want 111", ok, ok2, ok3);
      else n_pass++;
      n_total++;
      if (len_log[(d0 + 1) & 255] !== 8'd2) $display("FAIL split_len_second: got %0d want 2", len_log[(d0 + 1) & 255]);
      else n_pass++;
      n_total++;
      if (stream_errs(s) != 0) $display("FAIL split_stream: got %0d bytes/%0d errs want %0d bytes/0 errs", nrec - s, stream_errs(s), exp_d.size());
      else n_pass++;
      n_total++;
      if (n_rd - r0 != 6 || n_done - d0 != 2) $display("FAIL split_counts: got %0d pops/%0d frames want 6/2", n_rd - r0, n_done - d0);
      else n_pass++;
   endtask

   task automatic test_gap_ignore();
      int s, d0, g, viol;
      bit ok, ok2, ok3, ok4;
      pay_q.delete();
      load(8'h5A);
      build_expected();
      s = nrec; d0 = n_done;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 0, ok);
      xsnd = 1'b0;
      n_total++;
      if (stream_errs(s) != 0) $display("FAIL gap_first_stream: got %0d errs want 0", stream_errs(s));
      else n_pass++;
      pay_q.delete();
      load(8'h3C);
      s = nrec;
      g = 1;
      while (busy === 1'b1 && g < 400) begin
         g++;
         xsnd = (g >= 3 && g <= 15);
         step();
      end
      xsnd = 1'b0;
      n_total++;
      if (g != IFG) $display("FAIL gap_ignore_len: got %0d want %0d", g, IFG);
      else n_pass++;
      viol = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (busy !== 1'b0 || tx_valid !== 1'b0) viol++;
      end
      n_total++;
      if (viol != 0 || nrec != s) $display("FAIL gap_no_restart: got %0d busy cycles/%0d bytes want 0/0", viol, nrec - s);
      else n_pass++;
      build_expected();
      d0 = n_done;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 2, ok2);
      xsnd = 1'b0;
      wait_idle(ok3);
      ok4 = ok && ok2 && ok3;
      n_total++;
      if (!ok4 || stream_errs(s) != 0) $display("FAIL gap_second_frame: got ok=%b errs=%0d want ok=1 errs=0", ok4, stream_errs(s));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int guard, s, d0;
      bit ok, ok2;
      pay_q.delete();
      load(8'hA0); load(8'hB1); load(8'hC2);
      tx_ready = 1'b1;
      xsnd = 1'b1;
      guard = 0;
      while (!(tx_valid === 1'b1 && tx_data === 8'hB1) && guard < 200) begin
         step();
         guard++;
      end
      tx_ready = 1'b0;
      n_total++;
      if (guard >= 200) $display("FAIL midrst_reach: got timeout want second payload byte");
      else n_pass++;
      step();
      step();
      rst = 1'b1;
      #1;
      n_total++;
      if ({tx_valid, busy, fifo_rd} !== 3'b000) $display("FAIL midrst_outputs: got valid/busy/rd %b want 000", {tx_valid, busy, fifo_rd});
      else n_pass++;
      xsnd = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      pay_q.delete();
      pay_q.push_back(8'hC2);
      build_expected();
      s = nrec; d0 = n_done;
      xsnd = 1'b1;
      wait_frames(d0 + 1, 0, ok);
      xsnd = 1'b0;
      wait_idle(ok2);
      n_total++;
      if (!(ok && ok2) || stream_errs(s) != 0) $display("FAIL midrst_fresh_frame: got ok=%b%b errs=%0d want ok=11 errs=0", ok, ok2, stream_errs(s));
      else n_pass++;
      n_total++;
      if (len_log[d0 & 255] !== 8'd1) $display("FAIL midrst_payload_len: got %0d want 1", len_log[d0 & 255]);
      else n_pass++;
   endtask

   task automatic test_random();
      int n, mode, frames, lastlen, s, d0, r0, e0;
      bit ok, ok2;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 10);
         mode = $urandom_range(0, 2);
         pay_q.delete();
         for (int k = 0; k < n; k++) load(8'($urandom_range(0, 255)));
         build_expected();
         frames = (n + MAXP - 1) / MAXP;
         lastlen = n - MAXP * (frames - 1);
         s = nrec; d0 = n_done; r0 = n_rd; e0 = stab_err;
         xsnd = 1'b1;
         wait_frames(d0 + frames, mode, ok);
         xsnd = 1'b0;
         wait_idle(ok2);
         n_total++;
         if (!(ok && ok2) || stream_errs(s) != 0)
            $display("FAIL rand%0d_stream: got ok=%b%b bytes=%0d errs=%0d want ok=11 bytes=%0d errs=0", it, ok, ok2, nrec - s, stream_errs(s), exp_d.size());
         else n_pass++;
         n_total++;
         if (n_done - d0 != frames || len_log[(d0 + frames - 1) & 255] !== 8'(lastlen))
            $display("FAIL rand%0d_frames: got %0d frames len %0d want %0d frames len %0d", it, n_done - d0, len_log[(d0 + frames - 1) & 255], frames, lastlen);
         else n_pass++;
         n_total++;
         if (n_rd - r0 != n || stab_err != e0)
            $display("FAIL rand%0d_pops: got %0d pops/%0d hold errs want %0d/0", it, n_rd - r0, stab_err - e0, n);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b0;
      xsnd = 1'b0;
      tx_ready = 1'b0;
      #2;
      test_reset();
      test_single_byte();
      test_backpressure();
      test_empty_request();
      test_max_split();
      test_gap_ignore();
      test_reset_mid();
      test_random();
      n_total++;
      if (bad_pop != 0) $display("FAIL pop_while_empty: got %0d want 0", bad_pop);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tran_frame_ctrl.md
Name: tran_frame_ctrl

Overview:
- Transmit framer directly downstream of the transmitter byte FIFO (BRAM-backed, 256 x 8).
- On a send request, pops payload bytes from the FIFO and wraps them into a frame: preamble, SFD, payload, CRC-8.
- Hands the frame byte by byte to the serializer over a valid/ready handshake.
- Enforces an inter-frame gap before the next frame may start.

Parameters:
- PREAMBLE_LEN, 2, number of 0x55 preamble bytes (1..15).
- SFD_BYTE, 8'hD0, start-of-frame delimiter byte.
- MAX_PAYLOAD, 255, maximum payload bytes per frame (1..255).
- IFG_CYCLES, 16, idle clk_system cycles after the CRC byte is accepted (1..255).

Ports:
- clk_system  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- xsnd  in  1  send request, level; sampled in IDLE only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  single-cycle pop strobe.
- tx_data  out  8  frame byte to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts byte when tx_valid && tx_ready.
- tx_last  out  1  marks the CRC byte (qualified by tx_valid).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the CRC byte is accepted.
- payload_len  out  8  bytes sent in the last frame; updated with frame_done.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE.
  - fifo_rd=0, tx_valid=0, tx_last=0, busy=0, frame_done=0.
  - tx_data=8'h00, payload_len=8'h00, CRC register=8'h00, counters=0.
- Reset mid-frame abandons the frame immediately. Bytes already popped are lost; no further pop.
- Handshake: a byte transfers on a clk edge where tx_valid && tx_ready. Once tx_valid rises, tx_data and tx_last hold until the transfer.
- IDLE: if xsnd && !fifo_empty, go to PRE and clear the byte counter and CRC. If xsnd && fifo_empty, stay in IDLE (no empty frames).
- PRE: present 0x55 PREAMBLE_LEN times. After the last transfer, go to SFD.
- SFD: present SFD_BYTE. On transfer, go to FETCH.
- FETCH: assert fifo_rd for exactly one cycle, then go to WAIT. FETCH is only entered when fifo_empty was low at the decision point.
- WAIT: no outputs asserted. On the next edge:
  - capture fifo_data into tx_data;
  - set tx_valid;
  - update CRC with the byte;
  - increment the byte counter;
  - go to DATA.
- DATA: hold the byte until transfer, then evaluate on the transfer edge:
  - if counter < MAX_PAYLOAD and !fifo_empty, go to FETCH;
  - otherwise go to CRC.
  - fifo_empty is sampled at least 2 cycles after the prior fifo_rd, so the FIFO flag has settled.
- CRC: present the CRC register with tx_last=1. On transfer:
  - pulse frame_done;
  - load payload_len from the counter;
  - go to GAP.
- GAP: count IFG_CYCLES cycles with tx_valid=0, then go to IDLE. xsnd is ignored during GAP.
- CRC-8 rules:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over payload bytes only; preamble and SFD are excluded.
  - A one-cycle combinational update per byte is sufficient.
- Payload wrap: a counter reaching MAX_PAYLOAD ends the frame even if the FIFO still holds data. The remaining bytes start the next frame when xsnd is seen in IDLE.
- FIFO full/overflow is the FIFO's concern. This block never pops while fifo_empty is high.
- tx_ready may be held low indefinitely in any presenting state. The state is held, and no pop occurs while a byte is pending.

Test Plan:
- Single byte: PREAMBLE_LEN=2; FIFO holds {0x01}; xsnd=1; tx_ready=1.
  - tx stream is 0x55,0x55,0xD0,0x01,0x07.
  - tx_last only on 0x07; frame_done pulses once; payload_len=1.
  - Exactly one fifo_rd pulse.
- Two bytes with backpressure: FIFO holds {0x01,0x02}; tx_ready toggles 1/0 every cycle.
  - tx stream is 0x55,0x55,0xD0,0x01,0x02,0x1B.
  - tx_data stays stable while tx_valid && !tx_ready.
- Empty request: xsnd=1 with fifo_empty=1 for 20 cycles.
  - busy stays 0; fifo_rd stays 0; tx_valid stays 0.
- Max-payload split: MAX_PAYLOAD=4; FIFO holds 6 bytes; xsnd held high.
  - First frame has 4 payload bytes (payload_len=4).
  - Exactly IFG_CYCLES idle cycles follow the CRC byte.
  - Second frame has 2 payload bytes (payload_len=2).
- Mid-frame reset: assert rst during the 2nd payload byte with tx_ready=0.
  - Same cycle: tx_valid=0, busy=0, fifo_rd=0.
  - After release, xsnd with a non-empty FIFO starts a fresh preamble.
- Ignored request in GAP: xsnd pulsed during GAP.
  - No new frame starts until GAP expires.
  - A frame starts only if xsnd is high in IDLE.
